// File: rtl/pong_pkg.sv
// pong_pkg: shared Pong screen/wall/paddle/ball geometry and the motion FSM encoding.
// Geometry is kept 11 bits wide so that sums like ball_x+BALL_SZ cannot wrap in comparisons.
package pong_pkg;
    localparam logic [10:0] H_MAX   = 11'd640;
    localparam logic [10:0] V_MAX   = 11'd480;
    localparam logic [10:0] WALL_R  = 11'd35;
    localparam logic [10:0] PAD_L   = 11'd600;
    localparam logic [10:0] PAD_R   = 11'd603;
    localparam logic [10:0] PAD_H   = 11'd72;
    localparam logic [10:0] PAD_V   = 11'd4;
    localparam logic [10:0] BALL_SZ = 11'd8;
    localparam logic [10:0] BALL_V  = 11'd2;
    localparam logic [10:0] TOP_LIM  = BALL_V;
    localparam logic [10:0] BOT_LIM  = V_MAX - BALL_V;
    localparam logic [10:0] WALL_LIM = WALL_R + 11'd1 + BALL_V;
    localparam logic [10:0] MISS_LIM = H_MAX - 11'd1 - BALL_V;
    localparam logic [10:0] PAD_MAX  = V_MAX - PAD_H;
    localparam logic [9:0]  SERVE_X  = 10'd300;
    localparam logic [9:0]  SERVE_Y  = 10'd236;
    localparam logic [9:0]  PAD_RST  = 10'd204;
    localparam logic [5:0]  MISS_LAST = 6'd59;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_MISS = 2'd2
    } state_t;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-clock pulse at the start of each frame's vertical blanking.
//   clk, reset_n  : clock, asynchronous active-low reset
//   i_pixl_x/y    : current pixel coordinates from vga_sync
//   o_tick        : high for exactly one clk per frame, whatever the clk/pixel ratio
module frame_tick_gen
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] i_pixl_x,
    input  logic [9:0] i_pixl_y,
    output logic       o_tick
);
    logic w_fs;
    logic r_fs_q;

    assign w_fs = ({1'b0, i_pixl_y} == V_MAX + 11'd1) && (i_pixl_x == 10'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fs_q <= 1'b0;
        else          r_fs_q <= w_fs;
    end

    // the pixel may sit at (0,V_MAX+1) for several clks; only its first clk counts
    assign o_tick = w_fs & ~r_fs_q;
endmodule

// File: rtl/pong_motion_ctrl.sv
// pong_motion_ctrl: per-frame ball/paddle motion and serve/play/miss sequencing for Pong.
//   clk, reset_n       : clock, asynchronous active-low reset
//   pixl_x, pixl_y     : current pixel from vga_sync (frame tick source)
//   btn_up, btn_down   : paddle buttons (level)
//   serve              : launch request, sampled on the frame tick while idle
//   ball_x, ball_y     : ball top-left corner
//   pad_top            : paddle top edge
//   hit_cnt            : paddle hits since the last serve, saturating
//   miss               : one-clk pulse when the ball leaves on the right
//   play               : high while a rally is in progress
module pong_motion_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] pixl_x,
    input  logic [9:0] pixl_y,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] pad_top,
    output logic [7:0] hit_cnt,
    output logic       miss,
    output logic       play
);
    state_t     r_state;
    logic [9:0] r_ball_x, r_ball_y, r_pad_top;
    logic [7:0] r_hit_cnt;
    logic [5:0] r_frame_cnt;
    logic       r_dx_right, r_dy_down, r_miss, r_play;

    logic        w_tick;
    logic [10:0] w_bx, w_by, w_pt, w_rx, w_nx, w_ny, w_np;
    logic        w_hit_top, w_hit_bot, w_hit_wall, w_hit_pad, w_out;
    logic        w_ndx_right, w_ndy_down;

    frame_tick_gen u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_pixl_x (pixl_x),
        .i_pixl_y (pixl_y),
        .o_tick   (w_tick)
    );

    assign w_bx = {1'b0, r_ball_x};
    assign w_by = {1'b0, r_ball_y};
    assign w_pt = {1'b0, r_pad_top};
    // rightmost ball column after one more step to the right
    assign w_rx = w_bx + BALL_SZ - 11'd1 + BALL_V;

    assign w_hit_top  = w_by <= TOP_LIM;
    assign w_hit_bot  = w_by + BALL_SZ >= BOT_LIM;
    assign w_hit_wall = w_bx <= WALL_LIM;
    assign w_hit_pad  = r_dx_right && w_rx >= PAD_L && w_rx <= PAD_R &&
                        w_by + BALL_SZ - 11'd1 >= w_pt && w_by <= w_pt + PAD_H - 11'd1;
    assign w_out      = w_bx + BALL_SZ - 11'd1 >= MISS_LIM;

    // direction is resolved first, then the step uses the new direction
    assign w_ndy_down  = w_hit_top ? 1'b1 : (w_hit_bot ? 1'b0 : r_dy_down);
    assign w_ndx_right = w_hit_wall ? 1'b1 : (w_hit_pad ? 1'b0 : r_dx_right);
    assign w_nx = w_ndx_right ? w_bx + BALL_V : w_bx - BALL_V;
    assign w_ny = w_ndy_down ? w_by + BALL_V : w_by - BALL_V;

    // paddle clamps at both screen edges; opposing buttons cancel
    assign w_np = (btn_up && !btn_down) ? ((w_pt < PAD_V) ? 11'd0 : w_pt - PAD_V) :
                  (btn_down && !btn_up) ? ((w_pt + PAD_V > PAD_MAX) ? PAD_MAX : w_pt + PAD_V) :
                  w_pt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_ball_x    <= SERVE_X;
            r_ball_y    <= SERVE_Y;
            r_pad_top   <= PAD_RST;
            r_dx_right  <= 1'b0;
            r_dy_down   <= 1'b1;
            r_hit_cnt   <= 8'd0;
            r_frame_cnt <= 6'd0;
            r_miss      <= 1'b0;
            r_play      <= 1'b0;
        end else begin
            r_miss <= 1'b0;
            if (w_tick) begin
                r_pad_top <= w_np[9:0];
                case (r_state)
                    S_IDLE: begin
                        if (serve) begin
                            r_state    <= S_PLAY;
                            r_play     <= 1'b1;
                            r_hit_cnt  <= 8'd0;
                            r_dx_right <= 1'b0;
                            r_dy_down  <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (w_out) begin
                            r_state <= S_MISS;
                            r_play  <= 1'b0;
                            r_miss  <= 1'b1;
                        end else begin
                            r_dx_right <= w_ndx_right;
                            r_dy_down  <= w_ndy_down;
                            r_ball_x   <= w_nx[9:0];
                            r_ball_y   <= w_ny[9:0];
                            if (w_hit_pad && r_hit_cnt != 8'hff) r_hit_cnt <= r_hit_cnt + 8'd1;
                        end
                    end
                    S_MISS: begin
                        if (r_frame_cnt == MISS_LAST) begin
                            r_state     <= S_IDLE;
                            r_frame_cnt <= 6'd0;
                            r_ball_x    <= SERVE_X;
                            r_ball_y    <= SERVE_Y;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 6'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_play  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ball_x  = r_ball_x;
    assign ball_y  = r_ball_y;
    assign pad_top = r_pad_top;
    assign hit_cnt = r_hit_cnt;
    assign miss    = r_miss;
    assign play    = r_play;
endmodule

// File: tb/tb_pong_motion_ctrl.sv
// tb_pong_motion_ctrl: directed and random frame stimulus checked against a per-frame game model.
module tb_pong_motion_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] pixl_x, pixl_y;
    logic       btn_up, btn_down, serve;
    logic [9:0] ball_x, ball_y, pad_top;
    logic [7:0] hit_cnt;
    logic       miss, play;

    int total = 0;
    int bad = 0;
    int mx, my, vx, vy, mpad, mhits, mmode, mleft;
    bit mpulse;
    bit chase;

    always #5 clk = ~clk;

    pong_motion_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pixl_x   (pixl_x),
        .pixl_y   (pixl_y),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .serve    (serve),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .pad_top  (pad_top),
        .hit_cnt  (hit_cnt),
        .miss     (miss),
        .play     (play)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ball_x"}, ball_x, mx);
        check({tag, ".ball_y"}, ball_y, my);
        check({tag, ".pad_top"}, pad_top, mpad);
        check({tag, ".hit_cnt"}, hit_cnt, mhits);
        check({tag, ".play"}, play, (mmode == 1) ? 1 : 0);
        check({tag, ".miss"}, miss, mpulse);
    endtask

    // mode: 0 waiting for serve, 1 rally, 2 ball lost (mleft frames to go)
    task automatic model_reset();
        mx = 300; my = 236; vx = -1; vy = 1;
        mpad = 204; mhits = 0; mmode = 0; mleft = 0; mpulse = 0;
    endtask

    task automatic model_step(input bit up, input bit dn, input bit sv);
        int np;
        np = mpad;
        if (up && !dn) np = (mpad < 4) ? 0 : mpad - 4;
        else if (dn && !up) np = (mpad + 4 > 408) ? 408 : mpad + 4;
        mpulse = 0;
        if (mmode == 0) begin
            if (sv) begin mmode = 1; mhits = 0; vx = -1; vy = 1; end
        end else if (mmode == 1) begin
            if (mx + 7 >= 637) begin
                mmode = 2; mleft = 60; mpulse = 1;
            end else begin
                if (my <= 2) vy = 1;
                else if (my + 8 >= 478) vy = -1;
                if (mx <= 38) vx = 1;
                else if (vx == 1 && mx + 9 >= 600 && mx + 9 <= 603 && my + 7 >= mpad && my <= mpad + 71) begin
                    vx = -1;
                    if (mhits < 255) mhits++;
                end
                mx += 2 * vx;
                my += 2 * vy;
            end
        end else begin
            mleft--;
            if (mleft == 0) begin mmode = 0; mx = 300; my = 236; end
        end
        mpad = np;
    endtask

    // one frame: blanking pixel held two clks (one tick), then an ordinary pixel
    task automatic frame(input bit up, input bit dn, input bit sv);
        btn_up = up; btn_down = dn; serve = sv;
        pixl_x = 10'd0; pixl_y = 10'd481;
        @(negedge clk);
        model_step(up, dn, sv);
        check_all("tick");
        @(negedge clk);
        mpulse = 0;
        check_all("hold");
        pixl_x = 10'd5; pixl_y = 10'd10;
        @(negedge clk);
    endtask

    // keeps the paddle on the far half from the ball so the rally ends quickly
    task automatic run_to_miss();
        int n;
        bit u;
        n = 0;
        while (mmode != 2 && n < 2000) begin
            u = (my + 4 >= 240);
            frame(u, !u, mmode == 0);
            n++;
        end
        total++;
        assert (n < 2000) else begin
            bad++;
            $error("FAIL miss_timeout frames=%0d limit=2000", n);
        end
    endtask

    task automatic async_reset(input string tag);
        pixl_x = 10'd0; pixl_y = 10'd481;
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        pixl_x = 10'd5; pixl_y = 10'd10;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit u, d, s;
        reset_n = 1'b0; btn_up = 0; btn_down = 0; serve = 0;
        pixl_x = 10'd0; pixl_y = 10'd481;
        repeat (2) @(negedge clk);
        model_reset();
        check_all("reset");
        pixl_x = 10'd5; pixl_y = 10'd10;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        btn_up = 1; serve = 1; pixl_x = 10'd0; pixl_y = 10'd481;
        repeat (4) @(negedge clk);
        model_step(1, 0, 1);
        check_all("tick4");
        check("tick4.pad_once", pad_top, 200);
        check("tick4.play", play, 1);
        check("tick4.ball_x", ball_x, 300);
        pixl_x = 10'd5; pixl_y = 10'd10; btn_up = 0; serve = 0;
        @(negedge clk);
        frame(0, 0, 0);
        check("serve.ball_x", ball_x, 298);
        check("serve.ball_y", ball_y, 238);

        repeat (60) frame(1, 0, 0);
        check("pad.top_clamp", pad_top, 0);
        repeat (110) frame(0, 1, 0);
        check("pad.bot_clamp", pad_top, 408);
        repeat (5) frame(1, 1, 0);
        check("pad.both_hold", pad_top, 408);

        chase = 1;
        for (int f = 0; f < 2500; f++) begin
            if (mmode != 1) chase = ($urandom_range(0, 2) != 0);
            s = ($urandom_range(0, 7) == 0);
            if (chase && mmode == 1) begin
                u = (mpad + 36 > my + 6);
                d = (mpad + 36 < my + 2);
            end else begin
                u = 1'($urandom_range(0, 1));
                d = 1'($urandom_range(0, 1));
            end
            frame(u, d, s);
        end

        run_to_miss();
        repeat (59) frame(0, 0, 1);
        check("miss59.play", play, 0);
        check("miss59.frozen_x", ball_x, 630);
        frame(0, 0, 1);
        check("miss60.ball_x", ball_x, 300);
        check("miss60.ball_y", ball_y, 236);
        check("miss60.play", play, 0);
        frame(0, 0, 1);
        check("reserve.play", play, 1);

        run_to_miss();
        repeat (10) frame(0, 0, 0);
        async_reset("rst_in_miss");
        frame(0, 0, 0);
        repeat (40) frame(0, 0, 1);
        async_reset("rst_in_play");
        frame(0, 0, 1);
        frame(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
